// File: rtl/uart_rx_if.sv
// Host-side port bundle of uart_rx: receive fifo access and sticky error flags.
// master = host (pops bytes, clears flags), slave = receiver.
interface uart_rx_if;
  logic       o_busy;
  logic       o_frame_err;
  logic       o_overrun;
  logic       i_err_clr;
  logic       o_fifo_empty;
  logic       i_fifo_read;
  logic [7:0] o_fifo_rdata;

  modport master (
    input  o_busy, o_frame_err, o_overrun, o_fifo_empty, o_fifo_rdata,
    output i_err_clr, i_fifo_read
  );

  modport slave (
    output o_busy, o_frame_err, o_overrun, o_fifo_empty, o_fifo_rdata,
    input  i_err_clr, i_fifo_read
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, mid-bit sampling, bytes buffered in a show-ahead fifo; byte visible 1 cycle after stop sample.
// Full fifo drops the byte and sets sticky overrun. UART_RX_MAJORITY_EN selects 2-of-3 majority sampling.

module fifo #(
  parameter int Width = 8,
  parameter int Depth = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [Width-1:0] i_wdata,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [Width-1:0] o_rdata
);
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr, rd_ptr;
  logic [CntW-1:0]  count;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign o_full  = (count == CntW'(Depth));
  assign o_empty = (count == '0);
  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;
  assign o_rdata = mem[rd_ptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= i_wdata;
  end
endmodule

module uart_rx #(
  parameter int FifoDepth   = 4,
  parameter int BaudCycBits = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [BaudCycBits-1:0] c_baud_cyc,
  input  logic                   i_rx,
  uart_rx_if.slave               host
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [BaudCycBits-1:0] CycOne = 1;

  state_t                 state, state_nxt;
  logic [BaudCycBits-1:0] cyc_cnt, cyc_nxt;
  logic [2:0]             bit_cnt, bit_nxt;
  logic [7:0]             shreg, sh_nxt;
  logic                   rx_meta, rx_s, rx_prev;
  logic                   fall, tick, sample;
  logic                   push, ferr_set, ovr_set;
  logic                   frame_err, overrun;
  logic                   fifo_full, fifo_empty;
  logic [7:0]             fifo_rdata;

  assign fall = !rx_s && rx_prev;
  assign tick = (state != IDLE) && (cyc_cnt == '0);

`ifdef UART_RX_MAJORITY_EN
  // Two previous rx_s values; with the live rx_s they form the 3-sample vote window.
  logic [1:0] hist;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) hist <= 2'b11;
    else          hist <= {hist[0], rx_s};
  end
  assign sample = (rx_s & hist[0]) | (rx_s & hist[1]) | (hist[0] & hist[1]);
`else
  assign sample = rx_s;
`endif

  always_comb begin
    state_nxt = state;
    cyc_nxt   = cyc_cnt;
    bit_nxt   = bit_cnt;
    sh_nxt    = shreg;
    push      = 1'b0;
    ferr_set  = 1'b0;
    ovr_set   = 1'b0;
    case (state)
      IDLE: begin
        if (fall) begin
          state_nxt = START;
          cyc_nxt   = c_baud_cyc >> 1;
        end
      end
      START: begin
        if (tick) begin
          if (!sample) begin
            state_nxt = DATA;
            cyc_nxt   = c_baud_cyc;
            bit_nxt   = 3'd0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cyc_nxt = cyc_cnt - CycOne;
        end
      end
      DATA: begin
        if (tick) begin
          sh_nxt  = {sample, shreg[7:1]};
          bit_nxt = bit_cnt + 3'd1;
          cyc_nxt = c_baud_cyc;
          if (bit_cnt == 3'd7) state_nxt = STOP;
        end else begin
          cyc_nxt = cyc_cnt - CycOne;
        end
      end
      STOP: begin
        // Leaving mid stop bit gives half a bit of slack for back-to-back frames.
        if (tick) begin
          state_nxt = IDLE;
          if (!sample)        ferr_set = 1'b1;
          else if (fifo_full) ovr_set  = 1'b1;
          else                push     = 1'b1;
        end else begin
          cyc_nxt = cyc_cnt - CycOne;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      rx_prev   <= 1'b1;
      state     <= IDLE;
      cyc_cnt   <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_meta   <= i_rx;
      rx_s      <= rx_meta;
      rx_prev   <= rx_s;
      state     <= state_nxt;
      cyc_cnt   <= cyc_nxt;
      bit_cnt   <= bit_nxt;
      shreg     <= sh_nxt;
      frame_err <= ferr_set | (frame_err & ~host.i_err_clr);
      overrun   <= ovr_set  | (overrun   & ~host.i_err_clr);
    end
  end

  fifo #(.Width(8), .Depth(FifoDepth)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_wdata (shreg),
    .i_pop   (host.i_fifo_read),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_rdata (fifo_rdata)
  );

  assign host.o_busy       = (state != IDLE);
  assign host.o_frame_err  = frame_err;
  assign host.o_overrun    = overrun;
  assign host.o_fifo_empty = fifo_empty;
  assign host.o_fifo_rdata = fifo_rdata;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames driven bit-by-bit, expectations hand-computed.
module tb_uart_rx;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] baud;
  logic        rx;
  int          total = 0;
  int          bad = 0;

  uart_rx_if u_if ();

  uart_rx #(.FifoDepth(4), .BaudCycBits(16)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .c_baud_cyc (baud),
    .i_rx       (rx),
    .host       (u_if)
  );

  always #5 clk = ~clk;

  function automatic logic frame_bit(input logic [7:0] d, input logic stop, input int b);
    if (b == 0)      return 1'b0;
    else if (b <= 8) return d[b-1];
    else             return stop;
  endfunction

  task automatic do_reset(input logic [15:0] c);
    baud = c;
    rx = 1'b1;
    u_if.i_err_clr = 1'b0;
    u_if.i_fifo_read = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Drives one frame; m indexes negedges from the start-bit drive. Line is left at the stop value.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int glitch_at,
                            input int clr_at, output int ne_at, output int busy_cnt);
    int per;
    per = int'(baud) + 1;
    ne_at = -1;
    busy_cnt = 0;
    for (int m = 0; m < 10 * per; m++) begin
      @(negedge clk);
      if (ne_at < 0 && !u_if.o_fifo_empty) ne_at = m;
      if (u_if.o_busy) busy_cnt++;
      rx = frame_bit(d, stop, m / per) ^ (m == glitch_at);
      u_if.i_err_clr = (m == clr_at);
    end
  endtask

  task automatic test_reset();
    baud = 16'd7;
    rx = 1'b1;
    u_if.i_err_clr = 1'b0;
    u_if.i_fifo_read = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (u_if.o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", u_if.o_busy); end
    total++; if (u_if.o_frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b exp=0", u_if.o_frame_err); end
    total++; if (u_if.o_overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", u_if.o_overrun); end
    total++; if (u_if.o_fifo_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", u_if.o_fifo_empty); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int ne, bc;
    do_reset(16'd7);
    send_frame(8'hA5, 1'b1, -1, -1, ne, bc);
    rx = 1'b1;
    @(negedge clk);
    // start tick at edge 6, stop tick at edge 78, push lands at edge 79
    total++; if (ne !== 79) begin bad++; $display("FAIL basic_latency got=%0d exp=79", ne); end
    total++; if (bc !== 76) begin bad++; $display("FAIL basic_busy_cycles got=%0d exp=76", bc); end
    total++; if (u_if.o_fifo_empty !== 1'b0) begin bad++; $display("FAIL basic_empty got=%b exp=0", u_if.o_fifo_empty); end
    total++; if (u_if.o_fifo_rdata !== 8'hA5) begin bad++; $display("FAIL basic_rdata got=%h exp=a5", u_if.o_fifo_rdata); end
    total++; if (u_if.o_frame_err !== 1'b0) begin bad++; $display("FAIL basic_frame_err got=%b exp=0", u_if.o_frame_err); end
    total++; if (u_if.o_overrun !== 1'b0) begin bad++; $display("FAIL basic_overrun got=%b exp=0", u_if.o_overrun); end
  endtask

  task automatic test_false_start();
    int bc;
    do_reset(16'd7);
    bc = 0;
    for (int m = 0; m < 12; m++) begin
      @(negedge clk);
      if (u_if.o_busy) bc++;
      rx = (m >= 2);
    end
    total++; if (bc !== 4) begin bad++; $display("FAIL false_start_busy_cycles got=%0d exp=4", bc); end
    total++; if (u_if.o_busy !== 1'b0) begin bad++; $display("FAIL false_start_idle got=%b exp=0", u_if.o_busy); end
    total++; if (u_if.o_fifo_empty !== 1'b1) begin bad++; $display("FAIL false_start_empty got=%b exp=1", u_if.o_fifo_empty); end
  endtask

  task automatic test_frame_err();
    int ne, bc;
    do_reset(16'd7);
    // clear pulse coincides with the failing stop sample: the set must win
    send_frame(8'h3C, 1'b0, -1, 78, ne, bc);
    u_if.i_err_clr = 1'b0;
    @(negedge clk);
    total++; if (u_if.o_frame_err !== 1'b1) begin bad++; $display("FAIL ferr_set_wins got=%b exp=1", u_if.o_frame_err); end
    total++; if (u_if.o_fifo_empty !== 1'b1) begin bad++; $display("FAIL ferr_empty got=%b exp=1", u_if.o_fifo_empty); end
    bc = 0;
    for (int m = 0; m < 40; m++) begin
      @(negedge clk);
      if (u_if.o_busy) bc++;
    end
    total++; if (bc !== 0) begin bad++; $display("FAIL break_no_start got=%0d exp=0", bc); end
    rx = 1'b1;
    repeat (4) @(negedge clk);
    u_if.i_err_clr = 1'b1;
    @(negedge clk);
    u_if.i_err_clr = 1'b0;
    total++; if (u_if.o_frame_err !== 1'b0) begin bad++; $display("FAIL ferr_clear got=%b exp=0", u_if.o_frame_err); end
    send_frame(8'h5A, 1'b1, -1, -1, ne, bc);
    rx = 1'b1;
    @(negedge clk);
    total++; if (u_if.o_fifo_rdata !== 8'h5A || u_if.o_fifo_empty !== 1'b0) begin
      bad++; $display("FAIL ferr_recover got=%h/empty=%b exp=5a/empty=0", u_if.o_fifo_rdata, u_if.o_fifo_empty);
    end
  endtask

  task automatic test_overrun();
    int ne, bc;
    logic [7:0] exp;
    do_reset(16'd7);
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, -1, -1, ne, bc);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (u_if.o_overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b exp=1", u_if.o_overrun); end
    total++; if (u_if.o_frame_err !== 1'b0) begin bad++; $display("FAIL ovr_frame_err got=%b exp=0", u_if.o_frame_err); end
    for (int i = 1; i <= 4; i++) begin
      exp = 8'(i);
      total++; if (u_if.o_fifo_rdata !== exp || u_if.o_fifo_empty !== 1'b0) begin
        bad++; $display("FAIL ovr_pop%0d got=%h/empty=%b exp=%h/empty=0", i, u_if.o_fifo_rdata, u_if.o_fifo_empty, exp);
      end
      u_if.i_fifo_read = 1'b1;
      @(negedge clk);
      u_if.i_fifo_read = 1'b0;
    end
    total++; if (u_if.o_fifo_empty !== 1'b1) begin bad++; $display("FAIL ovr_drained got=%b exp=1", u_if.o_fifo_empty); end
    u_if.i_fifo_read = 1'b1;
    @(negedge clk);
    u_if.i_fifo_read = 1'b0;
    u_if.i_err_clr = 1'b1;
    @(negedge clk);
    u_if.i_err_clr = 1'b0;
    total++; if (u_if.o_overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b exp=0", u_if.o_overrun); end
    send_frame(8'hC3, 1'b1, -1, -1, ne, bc);
    rx = 1'b1;
    @(negedge clk);
    total++; if (ne !== 79 || u_if.o_fifo_rdata !== 8'hC3) begin
      bad++; $display("FAIL empty_pop_ignored got=%0d/%h exp=79/c3", ne, u_if.o_fifo_rdata);
    end
  endtask

  task automatic test_back_to_back();
    int ne, bc;
    logic [7:0] exp [3];
    exp[0] = 8'h00; exp[1] = 8'hFF; exp[2] = 8'h55;
    do_reset(16'd15);
    for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b1, -1, -1, ne, bc);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (u_if.o_frame_err !== 1'b0 || u_if.o_overrun !== 1'b0) begin
      bad++; $display("FAIL b2b_flags got=%b%b exp=00", u_if.o_frame_err, u_if.o_overrun);
    end
    for (int i = 0; i < 3; i++) begin
      total++; if (u_if.o_fifo_rdata !== exp[i] || u_if.o_fifo_empty !== 1'b0) begin
        bad++; $display("FAIL b2b_byte%0d got=%h/empty=%b exp=%h/empty=0", i, u_if.o_fifo_rdata, u_if.o_fifo_empty, exp[i]);
      end
      u_if.i_fifo_read = 1'b1;
      @(negedge clk);
      u_if.i_fifo_read = 1'b0;
    end
    total++; if (u_if.o_fifo_empty !== 1'b1) begin bad++; $display("FAIL b2b_drained got=%b exp=1", u_if.o_fifo_empty); end
  endtask

  task automatic test_glitch();
    int ne, bc;
    logic [7:0] exp;
`ifdef UART_RX_MAJORITY_EN
    exp = 8'h00;
`else
    exp = 8'h04;
`endif
    do_reset(16'd7);
    // negedge 28 = offset 4 of data bit 2; high only at the edge feeding its tick-cycle sample
    send_frame(8'h00, 1'b1, 28, -1, ne, bc);
    rx = 1'b1;
    @(negedge clk);
    total++; if (u_if.o_fifo_rdata !== exp || u_if.o_fifo_empty !== 1'b0) begin
      bad++; $display("FAIL glitch got=%h/empty=%b exp=%h/empty=0", u_if.o_fifo_rdata, u_if.o_fifo_empty, exp);
    end
  endtask

  task automatic test_reset_mid();
    int ne, bc;
    do_reset(16'd7);
    send_frame(8'h11, 1'b1, -1, -1, ne, bc);
    for (int m = 0; m < 40; m++) begin
      @(negedge clk);
      rx = frame_bit(8'hA5, 1'b1, m / 8);
    end
    rst_n = 1'b0;
    @(negedge clk);
    total++; if (u_if.o_busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b exp=0", u_if.o_busy); end
    total++; if (u_if.o_fifo_empty !== 1'b1) begin bad++; $display("FAIL rst_mid_empty got=%b exp=1", u_if.o_fifo_empty); end
    rx = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send_frame(8'h33, 1'b1, -1, -1, ne, bc);
    rx = 1'b1;
    @(negedge clk);
    total++; if (ne !== 79 || u_if.o_fifo_rdata !== 8'h33) begin
      bad++; $display("FAIL rst_mid_next got=%0d/%h exp=79/33", ne, u_if.o_fifo_rdata);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_basic();
    test_false_start();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_glitch();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
